// File: rtl/ahb_arbiter_pkg.sv
// AHB arbiter shared definitions: transfer/burst codes, master count and
// small helpers for burst length and grant encoding.
package ahb_pkg;

    localparam int unsigned N_MASTERS = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    // Beats remaining after the NONSEQ beat of a burst.
    function automatic logic [4:0] burst_count(input hburst_e burst);
        case (burst)
            WRAP4, INCR4:   burst_count = 5'd3;
            WRAP8, INCR8:   burst_count = 5'd7;
            WRAP16, INCR16: burst_count = 5'd15;
            default:        burst_count = 5'd0;
        endcase
    endfunction

    // Master index to one-hot grant; out-of-range falls back to master 0.
    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        case (idx)
            2'd1:    idx_to_onehot = 3'b010;
            2'd2:    idx_to_onehot = 3'b100;
            default: idx_to_onehot = 3'b001;
        endcase
    endfunction

    // One-hot grant to master index; anything not one-hot maps to master 0.
    function automatic logic [1:0] onehot_to_idx(input logic [2:0] grant);
        case (grant)
            3'b010:  onehot_to_idx = 2'd1;
            3'b100:  onehot_to_idx = 2'd2;
            default: onehot_to_idx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Bus-side signal bundle of the AHB arbiter. The slave modport is the
// arbiter's view; the master modport is the view of the masters/bus fabric.
interface ahb_arbiter_if;
    import ahb_pkg::*;

    logic [N_MASTERS-1:0]   Hbusreq;
    logic [N_MASTERS-1:0]   Hlock;
    logic [2*N_MASTERS-1:0] Htrans_m;
    logic [3*N_MASTERS-1:0] Hburst_m;
    logic                   Hready;
    logic [N_MASTERS-1:0]   Hgrant;
    logic [1:0]             Hmaster;
    logic [1:0]             Hmaster_data;
    logic                   Hmastlock;

    modport slave (
        input  Hbusreq, Hlock, Htrans_m, Hburst_m, Hready,
        output Hgrant, Hmaster, Hmaster_data, Hmastlock
    );

    modport master (
        output Hbusreq, Hlock, Htrans_m, Hburst_m, Hready,
        input  Hgrant, Hmaster, Hmaster_data, Hmastlock
    );

endinterface

// File: rtl/ahb_arbiter_rr_select.sv
// Combinational round-robin picker: scans requests starting one past the
// last winner and reports the first requester found.
module ahb_rr_select
    import ahb_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_winner_i,
    output logic [1:0] winner_o,
    output logic       any_req_o
);

    // Next candidate index in the ring 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            2'd0:    rr_next = 2'd1;
            2'd1:    rr_next = 2'd2;
            default: rr_next = 2'd0;
        endcase
    endfunction

    logic [1:0] cand_s;
    logic       hit_s;

    // Walk the ring once; the first requesting candidate wins.
    always_comb begin
        winner_o  = 2'd0;
        any_req_o = 1'b0;
        cand_s    = last_winner_i;
        hit_s     = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            cand_s    = rr_next(cand_s);
            hit_s     = req_i[cand_s] & ~any_req_o;
            winner_o  = hit_s ? cand_s : winner_o;
            any_req_o = any_req_o | hit_s;
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Three-master AHB arbiter: burst-aware handover point, round-robin winner
// selection, registered grant and address/data-phase owner indices.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic         Hclk,
    input  logic         Hreset,
    ahb_arbiter_if.slave bus
);

    localparam logic [1:0] DEF_IDX = 2'(DEFAULT_MASTER);

    logic [2:0] grant_q, grant_d;
    logic [1:0] master_q, master_d;
    logic [1:0] mdata_q, mdata_d;
    logic [1:0] last_q, last_d;
    logic       mastlock_q, mastlock_d;
    logic [4:0] cnt_q, cnt_d;

    htrans_e    owner_trans_s;
    hburst_e    owner_burst_s;
    logic [4:0] load_s;
    logic       owner_req_s;
    logic       owner_lock_s;
    logic       arb_ok_s;
    logic [1:0] winner_s;
    logic       any_req_s;
    logic [1:0] grant_idx_s;

    ahb_rr_select u_rr (
        .req_i         (bus.Hbusreq),
        .last_winner_i (last_q),
        .winner_o      (winner_s),
        .any_req_o     (any_req_s)
    );

    // Pick out the address-phase owner's transfer type, burst and request.
    always_comb begin
        case (master_q)
            2'd1: begin
                owner_trans_s = htrans_e'(bus.Htrans_m[3:2]);
                owner_burst_s = hburst_e'(bus.Hburst_m[5:3]);
            end
            2'd2: begin
                owner_trans_s = htrans_e'(bus.Htrans_m[5:4]);
                owner_burst_s = hburst_e'(bus.Hburst_m[8:6]);
            end
            default: begin
                owner_trans_s = htrans_e'(bus.Htrans_m[1:0]);
                owner_burst_s = hburst_e'(bus.Hburst_m[2:0]);
            end
        endcase
        owner_req_s  = bus.Hbusreq[master_q];
        owner_lock_s = bus.Hlock[master_q];
        load_s       = burst_count(owner_burst_s);
        grant_idx_s  = onehot_to_idx(grant_q);
    end

    // Decide whether the bus may change hands at this edge; a locked,
    // still-requesting owner always keeps it.
    always_comb begin
        arb_ok_s = (owner_trans_s == IDLE)
                 | ((owner_trans_s == NONSEQ) & (load_s == 5'd0) & (owner_burst_s != INCR))
                 | ((owner_trans_s == SEQ) & (cnt_q == 5'd1))
                 | ((owner_burst_s == INCR) & ~owner_req_s);
        if (owner_lock_s && owner_req_s) begin
            arb_ok_s = 1'b0;
        end else begin
            arb_ok_s = arb_ok_s;
        end
    end

    // Beat counter: load on NONSEQ, count down on SEQ, hold on BUSY/stall.
    always_comb begin
        cnt_d = cnt_q;
        if (!bus.Hready) begin
            cnt_d = cnt_q;
        end else if (owner_trans_s == NONSEQ) begin
            cnt_d = load_s;
        end else if ((owner_trans_s == SEQ) && (cnt_q != 5'd0)) begin
            cnt_d = cnt_q - 5'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Grant/last-winner next state; parking on the default master does not
    // move the round-robin pointer.
    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        if (bus.Hready && arb_ok_s) begin
            if (any_req_s) begin
                grant_d = idx_to_onehot(winner_s);
                last_d  = winner_s;
            end else begin
                grant_d = idx_to_onehot(DEF_IDX);
                last_d  = last_q;
            end
        end else begin
            grant_d = grant_q;
            last_d  = last_q;
        end
    end

    // Owner pipeline: granted master becomes address owner, which becomes
    // data owner, one accepted phase at a time.
    always_comb begin
        master_d   = master_q;
        mdata_d    = mdata_q;
        mastlock_d = mastlock_q;
        if (bus.Hready) begin
            master_d   = grant_idx_s;
            mdata_d    = master_q;
            mastlock_d = bus.Hlock[grant_idx_s];
        end else begin
            master_d   = master_q;
            mdata_d    = mdata_q;
            mastlock_d = mastlock_q;
        end
    end

    // State registers; reset abandons any burst and points master 0 first.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            grant_q    <= 3'b001;
            master_q   <= 2'd0;
            mdata_q    <= 2'd0;
            mastlock_q <= 1'b0;
            cnt_q      <= 5'd0;
            last_q     <= 2'd2;
        end else begin
            grant_q    <= grant_d;
            master_q   <= master_d;
            mdata_q    <= mdata_d;
            mastlock_q <= mastlock_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end

    assign bus.Hgrant       = grant_q;
    assign bus.Hmaster      = master_q;
    assign bus.Hmaster_data = mdata_q;
    assign bus.Hmastlock    = mastlock_q;

endmodule
